// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin req/gnt arbiter: registered one-hot grant, hold-time limit with
// forced release, and a per-requester block that holds until the request drops.
module req_gnt_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_vld,
    output logic                 hold_timeout,
    output logic [N-1:0]         blocked
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit LIMIT_ON = (MAX_HOLD != 0);
    localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [HW-1:0]   hold_cnt_r, hold_cnt_s;
    logic [IW-1:0]   last_owner_r, last_owner_s;
    logic [N-1:0]    gnt_r, gnt_s;
    logic [IW-1:0]   gnt_id_r, gnt_id_s;
    logic            gnt_vld_r, gnt_vld_s;
    logic            hold_timeout_r, hold_timeout_s;
    logic [N-1:0]    blocked_r, blocked_s;
    logic [N-1:0]    block_set_s;
    logic [N-1:0]    elig_s;
    logic [IW-1:0]   winner_s;

    // First eligible index strictly after 'last', wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] elig,
                                              input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic [IW:0]   sum;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end else begin
                sum = sum;
            end
            if (!found && elig[sum[IW-1:0]]) begin
                pick  = sum[IW-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign elig_s   = req & ~blocked_r;
    assign winner_s = rr_pick(elig_s, last_owner_r);

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s        = state_r;
        hold_cnt_s     = hold_cnt_r;
        last_owner_s   = last_owner_r;
        gnt_s          = gnt_r;
        gnt_id_s       = gnt_id_r;
        gnt_vld_s      = gnt_vld_r;
        hold_timeout_s = 1'b0;
        block_set_s    = '0;
        case (state_r)
            IDLE: begin
                if (|elig_s) begin
                    gnt_s        = ONE_HOT0 << winner_s;
                    gnt_id_s     = winner_s;
                    gnt_vld_s    = 1'b1;
                    hold_cnt_s   = HW'(1);
                    last_owner_s = winner_s;
                    state_s      = GRANT;
                end else begin
                    gnt_s     = '0;
                    gnt_id_s  = '0;
                    gnt_vld_s = 1'b0;
                end
            end
            GRANT: begin
                // A dropped request wins over the limit on the same edge.
                if (!req[last_owner_r]) begin
                    gnt_s      = '0;
                    gnt_id_s   = '0;
                    gnt_vld_s  = 1'b0;
                    hold_cnt_s = '0;
                    state_s    = IDLE;
                end else if (LIMIT_ON && (hold_cnt_r == MAX_HOLD_C)) begin
                    gnt_s          = '0;
                    gnt_id_s       = '0;
                    gnt_vld_s      = 1'b0;
                    hold_cnt_s     = '0;
                    hold_timeout_s = 1'b1;
                    block_set_s    = ONE_HOT0 << last_owner_r;
                    state_s        = IDLE;
                end else if (hold_cnt_r != {HW{1'b1}}) begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                gnt_s      = '0;
                gnt_id_s   = '0;
                gnt_vld_s  = 1'b0;
                hold_cnt_s = '0;
                state_s    = IDLE;
            end
        endcase
        blocked_s = (blocked_r & req) | block_set_s;
    end

    // Controller state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            hold_cnt_r     <= '0;
            last_owner_r   <= LAST_RST;
            gnt_r          <= '0;
            gnt_id_r       <= '0;
            gnt_vld_r      <= 1'b0;
            hold_timeout_r <= 1'b0;
            blocked_r      <= '0;
        end else begin
            state_r        <= state_s;
            hold_cnt_r     <= hold_cnt_s;
            last_owner_r   <= last_owner_s;
            gnt_r          <= gnt_s;
            gnt_id_r       <= gnt_id_s;
            gnt_vld_r      <= gnt_vld_s;
            hold_timeout_r <= hold_timeout_s;
            blocked_r      <= blocked_s;
        end
    end

    assign gnt          = gnt_r;
    assign gnt_id       = gnt_id_r;
    assign gnt_vld      = gnt_vld_r;
    assign hold_timeout = hold_timeout_r;
    assign blocked      = blocked_r;

endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// Scoreboard bench for req_gnt_rr_arbiter (N=4, MAX_HOLD=8): directed vectors
// push expected outputs; a monitor pops and compares after each rising edge.
module tb_req_gnt_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       hold_timeout;
    logic [3:0] blocked;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       to;
        logic [3:0] blk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    req_gnt_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_vld(gnt_vld),
        .hold_timeout(hold_timeout),
        .blocked(blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, expv);
        end
    endtask

    // Apply one request pattern for one cycle; expected outputs follow the next edge.
    task automatic vec(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eto, input logic [3:0] eb);
        exp_t e;
        e.g = eg; e.id = eid; e.to = eto; e.blk = eb;
        req = r;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",          vec_no, 32'(gnt),          32'(e.g));
            chk("gnt_id",       vec_no, 32'(gnt_id),       32'(e.id));
            chk("gnt_vld",      vec_no, 32'(gnt_vld),      32'(|e.g));
            chk("hold_timeout", vec_no, 32'(hold_timeout), 32'(e.to));
            chk("blocked",      vec_no, 32'(blocked),      32'(e.blk));
            vec_no++;
        end
    end

    initial begin
        logic [3:0] blk;
        req   = 4'b0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",     -1, 32'(gnt),          32'h0);
        chk("rst_gnt_id",  -1, 32'(gnt_id),       32'h0);
        chk("rst_gnt_vld", -1, 32'(gnt_vld),      32'h0);
        chk("rst_timeout", -1, 32'(hold_timeout), 32'h0);
        chk("rst_blocked", -1, 32'(blocked),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single pulse on requester 0
        vec(4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        // 0101 held: 0 owns until it drops, then a gap, then 2
        do_reset();
        vec(4'b0101, 4'b0001, 2'd0, 1'b0, 4'b0000);
        vec(4'b0101, 4'b0001, 2'd0, 1'b0, 4'b0000);
        vec(4'b0101, 4'b0001, 2'd0, 1'b0, 4'b0000);
        vec(4'b0100, 4'b0000, 2'd0, 1'b0, 4'b0000);
        vec(4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        // all four held: 8-cycle grants in order, each forced off
        do_reset();
        blk = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                vec(4'b1111, 4'b0001 << k, 2'(k), 1'b0, blk);
            end
            blk = blk | (4'b0001 << k);
            vec(4'b1111, 4'b0000, 2'd0, 1'b1, blk);
        end
        for (int c = 0; c < 3; c++) begin
            vec(4'b1111, 4'b0000, 2'd0, 1'b0, 4'b1111);
        end
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        // owner drops exactly when the count reaches the limit
        do_reset();
        for (int c = 0; c < 8; c++) begin
            vec(4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0000);
        end
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        // blocked recovery on requester 1
        for (int c = 0; c < 8; c++) begin
            vec(4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0000);
        end
        vec(4'b0010, 4'b0000, 2'd0, 1'b1, 4'b0010);
        vec(4'b0010, 4'b0000, 2'd0, 1'b0, 4'b0010);
        vec(4'b0010, 4'b0000, 2'd0, 1'b0, 4'b0010);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
        vec(4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        // asynchronous reset in the middle of a grant
        vec(4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000);
        vec(4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt",     -2, 32'(gnt),     32'h0);
        chk("async_gnt_vld", -2, 32'(gnt_vld), 32'h0);
        chk("async_blocked", -2, 32'(blocked), 32'h0);
        chk("async_gnt_id",  -2, 32'(gnt_id),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        vec(4'b1000, 4'b1000, 2'd3, 1'b0, 4'b0000);
        vec(4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", -3, 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_gnt_rr_arbiter.md
# req_gnt_rr_arbiter

Round-robin arbiter that shares one resource among N requesters using a single-bit req/gnt handshake per requester. A grant follows a sampled request by exactly one cycle and drops one cycle after the request drops, so every port obeys `req |=> gnt` and `(~req & gnt) ##1 (~req & ~gnt)` at release. A hold-time limit force-releases a requester that keeps the resource too long. The arbiter sits in front of the shared DUT resource, and its outputs feed the existing req/gnt property checks.

## Interface
- N, default 4: number of requesters (2..16).
- MAX_HOLD, default 8: maximum consecutive grant cycles. 0 disables the limit.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request; level, held while the resource is wanted.
- gnt  out  N  one-hot-or-zero grant, registered.
- gnt_id  out  $clog2(N)  index of the current owner; 0 when no grant is active.
- gnt_vld  out  1  OR of gnt, registered.
- hold_timeout  out  1  one-cycle pulse on a forced release.
- blocked  out  N  requester excluded after a timeout, registered.

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit high.
- Reset values:
  - gnt=0, gnt_id=0, gnt_vld=0, hold_timeout=0, blocked=0.
  - state=IDLE, hold_cnt=0, last_owner=N-1, so requester 0 has top priority.
- IDLE:
  - Eligible set = req & ~blocked.
  - If the eligible set is non-empty, the winner is the first eligible index scanning from (last_owner+1) mod N upward with wrap.
  - Set gnt[winner], gnt_id=winner, gnt_vld=1, hold_cnt=1, last_owner=winner, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, owner req sampled 0:
  - Clear gnt and gnt_vld, then go to IDLE.
  - gnt_id returns to 0.
- GRANT, owner req sampled 1, MAX_HOLD≠0 and hold_cnt==MAX_HOLD:
  - Force release: clear gnt and gnt_vld.
  - Pulse hold_timeout=1 for one cycle.
  - Set blocked[owner]=1, then go to IDLE.
- GRANT, otherwise: hold_cnt++ and keep the grant.
- Requests from non-owners are ignored while in GRANT. There is no preemption.
- blocked[i] clears on any edge where req[i] is sampled 0. A blocked requester must drop req for at least one cycle before it can be granted again.
- Width: hold_cnt is $clog2(MAX_HOLD+1) bits and never wraps, because the compare fires first. When MAX_HOLD=0, hold_cnt saturates.

## Timing
- Grant latency: req[i] sampled 1 at edge t in IDLE, with i the winner, gives gnt[i]=1 sampled at edge t+1.
- Release latency: owner req sampled 0 at edge t gives gnt=0 sampled at edge t+1.
- Gap: there is always at least one gnt=0 cycle between two grants, including back-to-back grants to different requesters. The next grant can be sampled at edge t+2 at the earliest.
- Hold limit: a grant issued at edge t holds at most through sample t+MAX_HOLD. gnt=0 and hold_timeout=1 are sampled at edge t+MAX_HOLD+1. hold_timeout=0 at edge t+MAX_HOLD+2.
- Same edge, owner drops req and hold_cnt==MAX_HOLD: this is a normal release. No hold_timeout pulse, blocked unchanged.
- Same edge, IDLE with several eligible requests: round-robin picks one winner and the others wait. No request is lost because req is a level.
- Reset mid-operation:
  - All outputs clear asynchronously on rst_n fall, with no clock edge needed.
  - The first grant after rst_n rises follows the IDLE rules with requester 0 at top priority.
- No combinational path from req to any output.

## Test plan
- N=4, single pulse: req=4'b0001 sampled at t → gnt=4'b0001 and gnt_id=0 at t+1. req low at t+1 → gnt=0 at t+2. No timeout pulse.
- After reset, req=4'b0101 held: gnt=0001 for as long as req0 is held. Drop req0 → one gnt=0 cycle, then gnt=0100 and gnt_id=2.
- MAX_HOLD=8, req=4'b1111 held continuously:
  - Grants come in order 0,1,2,3, each exactly 8 cycles long with a 1-cycle gap.
  - hold_timeout pulses after each grant.
  - blocked accumulates to 4'b1111, then gnt stays 0.
- Boundary: the owner drops req on the same edge hold_cnt reaches 8 → gnt drops, hold_timeout stays 0, blocked stays 0.
- Blocked recovery: req1 alone is held past timeout, so blocked[1]=1 and there is no regrant. req1 low for 1 cycle clears blocked[1]. req1 high again → gnt=0010 one cycle later.
- Async reset: assert rst_n=0 mid-grant between clock edges → gnt, gnt_vld and blocked read 0 immediately. Release reset with req=4'b1000 → gnt=1000 one cycle after it is first sampled.
